ltc_counter: RTL

- 48-bit local time counter (LTC) on the consumer side of the register block's LTC task interface.
- Services "read time" and "load time" task requests with single-cycle ack pulses.
- Provides a live count and a rollover strobe.
- Timestamps an asynchronous external event for firmware readout.

---
 rtl/ltc_counter_if.sv | 34 +++
 rtl/ltc_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ltc_counter_if.sv
// LTC task interface between the register block (master) and the counter (slave).
//
// Handshake: each request is a level held high by the master until it sees
// the matching one-cycle ack. The slave accepts a request only while its busy
// flag for that channel is clear, acks it exactly once in the following cycle,
// and re-arms only after the master has dropped the request. ltc_wr_data must
// be stable while ltc_wr_req is high. ltc_rd_data is valid in the ack cycle and
// holds until the next accepted read.
interface ltc_counter_if;
  logic        ltc_rd_req;
  logic        ltc_rd_ack;
  logic [47:0] ltc_rd_data;
  logic        ltc_wr_req;
  logic        ltc_wr_ack;
  logic [47:0] ltc_wr_data;

  modport master (
    output ltc_rd_req,
    output ltc_wr_req,
    output ltc_wr_data,
    input  ltc_rd_ack,
    input  ltc_rd_data,
    input  ltc_wr_ack
  );

  modport slave (
    input  ltc_rd_req,
    input  ltc_wr_req,
    input  ltc_wr_data,
    output ltc_rd_ack,
    output ltc_rd_data,
    output ltc_wr_ack
  );
endinterface

// File: rtl/ltc_counter.sv
// 48-bit local time counter: prescaled free-running count, read/load task
// channels with single-cycle acks, rollover strobe and external event stamp.
module ltc_counter #(
  parameter int unsigned P_PRESCALE = 1,
  parameter int unsigned P_EVT_SYNC = 2
) (
  input  logic               clk,
  input  logic               rst,
  ltc_counter_if.slave       ltc,
  output logic [47:0]        ltc_now,
  output logic               ltc_rollover,
  input  logic               evt_in,
  output logic [47:0]        evt_ts,
  output logic               evt_valid,
  input  logic               evt_clr
);

  localparam logic [15:0] PC_MAX = 16'(P_PRESCALE - 1);

  logic [47:0]           now_d, now_q;
  logic [15:0]           pc_d, pc_q;
  logic [47:0]           rd_data_d, rd_data_q;
  logic                  rd_ack_d, rd_ack_q;
  logic                  wr_ack_d, wr_ack_q;
  logic                  roll_d, roll_q;
  logic                  rd_busy_d, rd_busy_q;
  logic                  wr_busy_d, wr_busy_q;
  logic [P_EVT_SYNC-1:0] sync_d, sync_q;
  logic                  dly_d, dly_q;
  logic                  edge_d, edge_q;
  logic [47:0]           evt_ts_d, evt_ts_q;
  logic                  evt_valid_d, evt_valid_q;

  logic                  rd_take;
  logic                  wr_take;
  logic                  carry;

  // Next-state logic for the counter, both task channels and event capture.
  always_comb begin
    now_d       = now_q;
    pc_d        = pc_q;
    rd_data_d   = rd_data_q;
    roll_d      = 1'b0;
    carry       = 1'b0;
    evt_ts_d    = evt_ts_q;
    evt_valid_d = evt_valid_q;

    rd_take = ltc.ltc_rd_req && !rd_busy_q;
    wr_take = ltc.ltc_wr_req && !wr_busy_q;

    // Acks are one-cycle echoes of acceptance; busy simply follows the
    // request level, which is 1 on acceptance and drops once req is released.
    rd_ack_d  = rd_take;
    wr_ack_d  = wr_take;
    rd_busy_d = ltc.ltc_rd_req;
    wr_busy_d = ltc.ltc_wr_req;

    // Snapshot is the pre-load, pre-increment count.
    if (rd_take) begin
      rd_data_d = now_q;
    end

    // A load wins over any increment due on the same edge and restarts the
    // prescale period; it never raises the rollover strobe.
    if (wr_take) begin
      now_d = ltc.ltc_wr_data;
      pc_d  = '0;
    end else if (pc_q == PC_MAX) begin
      pc_d           = '0;
      {carry, now_d} = {1'b0, now_q} + 49'd1;
      roll_d         = carry;
    end else begin
      pc_d = pc_q + 16'd1;
    end

    // Event path: synchronizer, delay flop, registered rise pulse.
    if (P_EVT_SYNC > 1) begin
      sync_d = {sync_q[P_EVT_SYNC-2:0], evt_in};
    end else begin
      sync_d = evt_in;
    end
    dly_d  = sync_q[P_EVT_SYNC-1];
    edge_d = sync_q[P_EVT_SYNC-1] && !dly_q;

    // First event wins unless firmware clears in the same cycle, in which
    // case the new capture replaces the old one.
    if (edge_q && (!evt_valid_q || evt_clr)) begin
      evt_ts_d    = now_q;
      evt_valid_d = 1'b1;
    end else if (evt_clr) begin
      evt_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      now_q       <= '0;
      pc_q        <= '0;
      rd_data_q   <= '0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      roll_q      <= 1'b0;
      rd_busy_q   <= 1'b0;
      wr_busy_q   <= 1'b0;
      sync_q      <= '0;
      dly_q       <= 1'b0;
      edge_q      <= 1'b0;
      evt_ts_q    <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      now_q       <= now_d;
      pc_q        <= pc_d;
      rd_data_q   <= rd_data_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      roll_q      <= roll_d;
      rd_busy_q   <= rd_busy_d;
      wr_busy_q   <= wr_busy_d;
      sync_q      <= sync_d;
      dly_q       <= dly_d;
      edge_q      <= edge_d;
      evt_ts_q    <= evt_ts_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign ltc.ltc_rd_ack  = rd_ack_q;
  assign ltc.ltc_rd_data = rd_data_q;
  assign ltc.ltc_wr_ack  = wr_ack_q;
  assign ltc_now         = now_q;
  assign ltc_rollover    = roll_q;
  assign evt_ts          = evt_ts_q;
  assign evt_valid       = evt_valid_q;

endmodule
